alu_bist: RTL and testbench
===========================

// Module: alu_bist
// PURPOSE
// Synthesizable built-in self-test initiator for the 8-bit ALU (responder side: InputA/InputB/OP -> Out/BranchFlag).
// Sweeps every op_mne opcode with a directed vector plus LFSR-generated operands, checks each ALU response
// against an internal golden model, and reports pass/fail, error count and first failing opcode.
// Sits beside the ALU in the datapath; drives the ALU inputs through a mux while Busy=1.
// PARAMETERS
// NUM_OPS    12      opcodes swept, encodings 0..NUM_OPS-1 (ADD=0,SUB,LSH,RSH,MOV,XOR,AND,OR,BGE,BNE,RXOR,BEQ=11)
// VECTORS    16      operand vectors per opcode (>=1); vector 0 is directed, rest from LFSR
// ALU_LAT    0       extra ALU pipeline cycles between operand drive and result sampling
// LFSR_SEED  8'hA5   nonzero reset seed of the operand LFSR
// PORTS
// Clk            in   1  clock, rising edge
// Reset          in   1  synchronous, active-high reset
// Start          in   1  one-cycle request to begin a sweep (sampled only in IDLE/DONE)
// Busy           out  1  high while sweep in progress
// Done           out  1  high from sweep completion until next Start or Reset
// Pass           out  1  valid when Done=1: 1 iff ErrCount==0
// ErrCount       out  8  mismatching vectors, saturating at 8'hFF
// FailOP         out  4  opcode of first mismatch; 4'hF if none
// OP             out  4  opcode driven to ALU
// InputA         out  8  operand A driven to ALU
// InputB         out  8  operand B driven to ALU
// AluOut         in   8  ALU Out
// AluBranchFlag  in   1  ALU BranchFlag
// BEHAVIOUR
// - Reset: state IDLE, Busy=0, Done=0, Pass=0, ErrCount=0, FailOP=4'hF, OP=0, InputA=0, InputB=0, LFSR=LFSR_SEED.
// - States: IDLE -Start-> DRIVE -> WAIT (ALU_LAT cycles; skipped if 0) -> CHECK -> DRIVE (next vector) | DONE.
// - DONE -Start-> DRIVE (clears ErrCount, FailOP, Done; LFSR NOT reseeded). Start in DRIVE/WAIT/CHECK ignored.
// - DRIVE: registers OP, InputA, InputB. Vector 0: A=8'h0A, B=8'h01. Vector k>0: A=LFSR, B=LFSR stepped once;
//   LFSR advances two steps per random vector. LFSR: Galois, taps x^8+x^6+x^5+x^4+1, never reaches zero.
// - CHECK: samples AluOut/AluBranchFlag; operands held stable from DRIVE through CHECK.
// - Per vector 2+ALU_LAT cycles; sweep = NUM_OPS*VECTORS*(2+ALU_LAT) cycles from Start to Done rising.
// - Order: all VECTORS of opcode 0, then opcode 1, ... ; after last vector of NUM_OPS-1 -> DONE, OP holds last value.
// - Golden model (8-bit, mod 256, unsigned): ADD A+B; SUB A-B; LSH A<<B[2:0]; RSH A>>B[2:0] (logical); MOV B;
//   XOR A^B; AND A&B; OR A|B; RXOR {7'b0,^A}; BGE flag=(A>=B); BNE flag=(A!=B); BEQ flag=(A==B).
// - Compare: non-branch ops compare AluOut only; BGE/BNE/BEQ compare AluBranchFlag only.
// - Mismatch: ErrCount+1 unless 8'hFF; FailOP loaded only if still 4'hF.
// - Pass=(ErrCount==0) registered when entering DONE; Pass=0 whenever Done=0.
// - Reset mid-sweep: next cycle all outputs at reset values; no partial result retained.
// - Opcodes >= 12 (if NUM_OPS raised) have no golden entry: counted as pass.
// CONFIGURATION
// ALU_BIST_FAILLOG_EN defined: extra outputs FailA[7:0], FailB[7:0], FailGot[7:0] capture operands and observed
//   value (branch ops: {7'b0,AluBranchFlag}) of the first mismatch, loaded with FailOP; reset/Start clear to 0.
// Not defined: those ports and registers absent; only FailOP reports the failure.
// TESTING
// 1. Correct ALU model, defaults, Start at cycle 5 -> Busy 384 cycles, Done=1, Pass=1, ErrCount=0, FailOP=4'hF.
// 2. ALU Out forced 8'h00 when OP=ADD -> first check sees 8'h00 vs 8'h0B; FailOP=0, Pass=0, ErrCount>=1.
// 3. AluBranchFlag stuck 0 -> first failure at BGE (0x0A>=0x01): FailOP=8, ErrCount>=1.
// 4. Reset asserted 100 cycles into sweep -> next cycle Busy=0, ErrCount=0, OP=0; new Start reruns from ADD.
// 5. Start pulsed at cycles 20 and 50 of a sweep -> ignored; Done still exactly 384 cycles after first Start.
// 6. ALU Out always inverted, VECTORS=32 -> ErrCount saturates at 8'hFF, FailOP=0, Pass=0.
// 7. ALU_LAT=2 with 2-stage piped ALU model -> 768-cycle sweep, Pass=1.

Source files
------------

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test initiator that sweeps every ALU opcode and checks responses against a golden model.
// Define ALU_BIST_FAILLOG_EN to add FailA/FailB/FailGot capture of the first mismatching vector.
module alu_bist #(
    parameter int unsigned NUM_OPS   = 12,
    parameter int unsigned VECTORS   = 16,
    parameter int unsigned ALU_LAT   = 0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [7:0] ErrCount,
    output logic [3:0] FailOP,
    output logic [3:0] OP,
    output logic [7:0] InputA,
    output logic [7:0] InputB,
    input  logic [7:0] AluOut,
    input  logic       AluBranchFlag,
`ifdef ALU_BIST_FAILLOG_EN
    output logic [7:0] FailA,
    output logic [7:0] FailB,
    output logic [7:0] FailGot,
`endif
    output logic [2:0] DbgState
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned VW = $clog2(VECTORS + 1);
    localparam int unsigned LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [VW-1:0] VEC_LAST  = VW'(VECTORS - 1);
    localparam logic [3:0]    OP_LAST   = 4'(NUM_OPS - 1);
    localparam logic [LW-1:0] WAIT_LAST = LW'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);

    // Galois form of x^8+x^6+x^5+x^4+1: shift left, fold the dropped x^8 term back in as 0x71.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h71 : 8'h00);
    endfunction

    logic [2:0]    state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [VW-1:0] vec_q, vec_d;
    logic [LW-1:0] wait_q, wait_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [3:0]    op_out_q, op_out_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    err_q, err_d;
    logic [3:0]    fail_op_q, fail_op_d;
    logic          pass_q, pass_d;
`ifdef ALU_BIST_FAILLOG_EN
    logic [7:0]    fail_a_q, fail_a_d;
    logic [7:0]    fail_b_q, fail_b_d;
    logic [7:0]    fail_got_q, fail_got_d;
`endif

    logic [7:0] lfsr_s1, lfsr_s2;
    logic [7:0] exp_out, observed, expected;
    logic       exp_flag, is_branch, has_golden, mismatch;

    assign lfsr_s1 = lfsr_step(lfsr_q);
    assign lfsr_s2 = lfsr_step(lfsr_s1);

    always_comb begin
        exp_out    = 8'h00;
        exp_flag   = 1'b0;
        is_branch  = 1'b0;
        has_golden = 1'b1;
        case (op_out_q)
            4'd0:    exp_out = a_q + b_q;
            4'd1:    exp_out = a_q - b_q;
            4'd2:    exp_out = a_q << b_q[2:0];
            4'd3:    exp_out = a_q >> b_q[2:0];
            4'd4:    exp_out = b_q;
            4'd5:    exp_out = a_q ^ b_q;
            4'd6:    exp_out = a_q & b_q;
            4'd7:    exp_out = a_q | b_q;
            4'd8:    begin is_branch = 1'b1; exp_flag = (a_q >= b_q); end
            4'd9:    begin is_branch = 1'b1; exp_flag = (a_q != b_q); end
            4'd10:   exp_out = {7'b0, ^a_q};
            4'd11:   begin is_branch = 1'b1; exp_flag = (a_q == b_q); end
            default: has_golden = 1'b0;
        endcase
    end

    // Branch opcodes are judged on the flag alone, everything else on Out alone.
    assign observed = is_branch ? {7'b0, AluBranchFlag} : AluOut;
    assign expected = is_branch ? {7'b0, exp_flag} : exp_out;
    assign mismatch = has_golden && (observed != expected);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        vec_d     = vec_q;
        wait_d    = wait_q;
        lfsr_d    = lfsr_q;
        op_out_d  = op_out_q;
        a_d       = a_q;
        b_d       = b_q;
        err_d     = err_q;
        fail_op_d = fail_op_q;
        pass_d    = pass_q;
`ifdef ALU_BIST_FAILLOG_EN
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_got_d = fail_got_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d   = S_DRIVE;
                    op_d      = 4'd0;
                    vec_d     = '0;
                    err_d     = 8'h00;
                    fail_op_d = 4'hF;
                    pass_d    = 1'b0;
`ifdef ALU_BIST_FAILLOG_EN
                    fail_a_d   = 8'h00;
                    fail_b_d   = 8'h00;
                    fail_got_d = 8'h00;
`endif
                end
            end
            S_DRIVE: begin
                op_out_d = op_q;
                wait_d   = '0;
                state_d  = (ALU_LAT == 0) ? S_CHECK : S_WAIT;
                if (vec_q == '0) begin
                    a_d = 8'h0A;
                    b_d = 8'h01;
                end else begin
                    a_d    = lfsr_q;
                    b_d    = lfsr_s1;
                    lfsr_d = lfsr_s2;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) state_d = S_CHECK;
                else wait_d = wait_q + LW'(1);
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    if (fail_op_q == 4'hF) begin
                        fail_op_d = op_out_q;
`ifdef ALU_BIST_FAILLOG_EN
                        fail_a_d   = a_q;
                        fail_b_d   = b_q;
                        fail_got_d = observed;
`endif
                    end
                end
                state_d = S_DRIVE;
                if (vec_q == VEC_LAST) begin
                    vec_d = '0;
                    if (op_q == OP_LAST) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == 8'h00);
                    end else begin
                        op_d = op_q + 4'd1;
                    end
                end else begin
                    vec_d = vec_q + VW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            op_q      <= 4'd0;
            vec_q     <= '0;
            wait_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            op_out_q  <= 4'd0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            err_q     <= 8'h00;
            fail_op_q <= 4'hF;
            pass_q    <= 1'b0;
`ifdef ALU_BIST_FAILLOG_EN
            fail_a_q   <= 8'h00;
            fail_b_q   <= 8'h00;
            fail_got_q <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            vec_q     <= vec_d;
            wait_q    <= wait_d;
            lfsr_q    <= lfsr_d;
            op_out_q  <= op_out_d;
            a_q       <= a_d;
            b_q       <= b_d;
            err_q     <= err_d;
            fail_op_q <= fail_op_d;
            pass_q    <= pass_d;
`ifdef ALU_BIST_FAILLOG_EN
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_got_q <= fail_got_d;
`endif
        end
    end

    assign Busy     = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign Done     = (state_q == S_DONE);
    assign Pass     = pass_q;
    assign ErrCount = err_q;
    assign FailOP   = fail_op_q;
    assign OP       = op_out_q;
    assign InputA   = a_q;
    assign InputB   = b_q;
    assign DbgState = state_q;
`ifdef ALU_BIST_FAILLOG_EN
    assign FailA    = fail_a_q;
    assign FailB    = fail_b_q;
    assign FailGot  = fail_got_q;
`endif

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: drives two alu_bist instances (defaults, and VECTORS=32/ALU_LAT=2 with a piped ALU) against
// behavioural ALU responders with selectable faults, and checks sweep timing, operand sequence and verdicts.
module tb_alu_bist;

    localparam int NOPS = 12;
    localparam int NV0  = 16;
    localparam int NV1  = 32;
    localparam int LAT1 = 2;

    typedef struct {
        int sel;
        int mode;
        bit extra;
        int exp_pass;
        int exp_fop;
        int exp_err;
    } sweep_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_s [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic [7:0] err_s   [2];
    logic [3:0] failop_s[2];
    logic [3:0] op_s    [2];
    logic [7:0] a_s     [2];
    logic [7:0] b_s     [2];
    logic [7:0] out_s   [2];
    logic       flag_s  [2];
    logic [2:0] dbg_s   [2];
    int         mode_s  [2];
    int         fault_op;
    logic [7:0] mdl_lfsr[2];
    logic [8:0] pipe1 = 9'h0;
    logic [8:0] pipe2 = 9'h0;

    int n_checks = 0;
    int n_pass   = 0;

    // Responder-side reference: ALU results from the operation definitions, {flag, out}.
    function automatic logic [8:0] golden(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int av, bv, sh;
        logic [7:0] o;
        logic f;
        av = int'(a); bv = int'(b); sh = 1 << (bv % 8);
        o = 8'h00; f = 1'b0;
        case (op)
            4'd0:  o = 8'((av + bv) % 256);
            4'd1:  o = 8'((av - bv + 256) % 256);
            4'd2:  o = 8'((av * sh) % 256);
            4'd3:  o = 8'(av / sh);
            4'd4:  o = b;
            4'd5:  o = a ^ b;
            4'd6:  o = a & b;
            4'd7:  o = a | b;
            4'd8:  f = (av >= bv);
            4'd9:  f = (av != bv);
            4'd10: o = 8'($countones(a) % 2);
            4'd11: f = (av == bv);
            default: ;
        endcase
        return {f, o};
    endfunction

    function automatic logic [8:0] alu_resp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                            input int m);
        logic [8:0] r;
        r = golden(op, a, b);
        case (m)
            1: if (op == 4'd0) r[7:0] = 8'h00;
            2: r[8] = 1'b0;
            3: r = ~r;
            4: if (int'(op) == fault_op) r = r ^ 9'h101;
            default: ;
        endcase
        return r;
    endfunction

    function automatic bit is_mismatch(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int m);
        logic [8:0] g, r;
        g = golden(op, a, b);
        r = alu_resp(op, a, b, m);
        if (op == 4'd8 || op == 4'd9 || op == 4'd11) return g[8] != r[8];
        return g[7:0] != r[7:0];
    endfunction

    // Multiply by x modulo x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic [8:0] t;
        t = {v, 1'b0};
        if (t[8]) t = t ^ 9'h171;
        return t[7:0];
    endfunction

    assign {flag_s[0], out_s[0]} = alu_resp(op_s[0], a_s[0], b_s[0], mode_s[0]);

    always @(posedge clk) begin
        pipe1 <= alu_resp(op_s[1], a_s[1], b_s[1], mode_s[1]);
        pipe2 <= pipe1;
    end
    assign {flag_s[1], out_s[1]} = pipe2;

    alu_bist dut0 (
        .Clk(clk), .Reset(rst), .Start(start_s[0]), .Busy(busy_s[0]), .Done(done_s[0]), .Pass(pass_s[0]),
        .ErrCount(err_s[0]), .FailOP(failop_s[0]), .OP(op_s[0]), .InputA(a_s[0]), .InputB(b_s[0]),
        .AluOut(out_s[0]), .AluBranchFlag(flag_s[0]), .DbgState(dbg_s[0])
    );

    alu_bist #(.VECTORS(NV1), .ALU_LAT(LAT1)) dut1 (
        .Clk(clk), .Reset(rst), .Start(start_s[1]), .Busy(busy_s[1]), .Done(done_s[1]), .Pass(pass_s[1]),
        .ErrCount(err_s[1]), .FailOP(failop_s[1]), .OP(op_s[1]), .InputA(a_s[1]), .InputB(b_s[1]),
        .AluOut(out_s[1]), .AluBranchFlag(flag_s[1]), .DbgState(dbg_s[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic check_reset_state(input int s);
        check("rst_busy_done_pass", {busy_s[s], done_s[s], pass_s[s]}, 3'b000);
        check("rst_err_failop", {err_s[s], failop_s[s]}, {8'h00, 4'hF});
        check("rst_op_a_b", {op_s[s], a_s[s], b_s[s]}, 20'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_lfsr[0] = 8'hA5;
        mdl_lfsr[1] = 8'hA5;
    endtask

    task automatic run_sweep(input int s, input int m, input bit extra, input int exp_pass,
                             input int exp_fop, input int exp_err);
        int nv, per, total, mdl_err, mdl_fop, seq_bad, win_bad;
        logic [7:0] lf, va, vb;
        logic [19:0] exp_q[$];
        logic [19:0] e;
        nv = (s == 0) ? NV0 : NV1;
        per = (s == 0) ? 2 : 2 + LAT1;
        total = NOPS * nv * per;
        mdl_err = 0;
        mdl_fop = 15;
        lf = mdl_lfsr[s];
        for (int op = 0; op < NOPS; op++) begin
            for (int v = 0; v < nv; v++) begin
                if (v == 0) begin
                    va = 8'h0A; vb = 8'h01;
                end else begin
                    va = lf; vb = lfsr_next(lf); lf = lfsr_next(vb);
                end
                exp_q.push_back({4'(op), va, vb});
                if (is_mismatch(4'(op), va, vb, m)) begin
                    if (mdl_err < 255) mdl_err++;
                    if (mdl_fop == 15) mdl_fop = op;
                end
            end
        end
        mdl_lfsr[s] = lf;
        mode_s[s] = m;
        start_s[s] = 1'b1;
        @(negedge clk);
        start_s[s] = 1'b0;
        check("clear_on_start", {err_s[s], failop_s[s], done_s[s], pass_s[s]}, {8'h00, 4'hF, 1'b0, 1'b0});
        seq_bad = 0;
        win_bad = 0;
        for (int j = 0; j < total; j++) begin
            start_s[s] = extra && (j == 20 || j == 50);
            if (busy_s[s] !== 1'b1 || done_s[s] !== 1'b0) win_bad++;
            if (j % per == per - 1) begin
                e = exp_q.pop_front();
                if ({op_s[s], a_s[s], b_s[s]} !== e) seq_bad++;
            end
            @(negedge clk);
        end
        start_s[s] = 1'b0;
        check("busy_window", 32'(win_bad), 0);
        check("operand_seq", 32'(seq_bad), 0);
        check("done_at_end", {busy_s[s], done_s[s]}, 2'b01);
        check("op_holds_last", op_s[s], 4'hB);
        check("pass", pass_s[s], 32'(exp_pass));
        check("err_vs_model", err_s[s], 32'(mdl_err));
        check("failop_vs_model", failop_s[s], 32'(mdl_fop));
        if (exp_fop >= 0) check("failop_table", failop_s[s], 32'(exp_fop));
        if (exp_err >= 0) check("err_table", err_s[s], 32'(exp_err));
    endtask

    sweep_t tbl[6];

    initial begin
        tbl[0] = '{sel: 0, mode: 0, extra: 1'b0, exp_pass: 1, exp_fop: 15, exp_err: 0};
        tbl[1] = '{sel: 0, mode: 0, extra: 1'b1, exp_pass: 1, exp_fop: 15, exp_err: 0};
        tbl[2] = '{sel: 0, mode: 1, extra: 1'b0, exp_pass: 0, exp_fop: 0,  exp_err: -1};
        tbl[3] = '{sel: 0, mode: 2, extra: 1'b0, exp_pass: 0, exp_fop: 8,  exp_err: -1};
        tbl[4] = '{sel: 1, mode: 0, extra: 1'b0, exp_pass: 1, exp_fop: 15, exp_err: 0};
        tbl[5] = '{sel: 1, mode: 3, extra: 1'b0, exp_pass: 0, exp_fop: 0,  exp_err: 255};

        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        mode_s[0] = 0;
        mode_s[1] = 0;
        fault_op = 0;
        do_reset();
        check_reset_state(0);
        check_reset_state(1);
        repeat (2) @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            run_sweep(tbl[t].sel, tbl[t].mode, tbl[t].extra, tbl[t].exp_pass, tbl[t].exp_fop, tbl[t].exp_err);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Single-opcode fault on a random opcode: every vector of that opcode mismatches.
        for (int r = 0; r < 2; r++) begin
            fault_op = int'($urandom_range(0, NOPS - 1));
            run_sweep(0, 4, 1'b0, 0, fault_op, NV0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Reset 100 cycles into a failing sweep discards everything; a fresh sweep restarts from ADD and the seed.
        mode_s[0] = 1;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (99) @(negedge clk);
        check("busy_mid_sweep", busy_s[0], 1'b1);
        check("err_before_reset", {31'b0, err_s[0] != 8'h00}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_lfsr[0] = 8'hA5;
        mdl_lfsr[1] = 8'hA5;
        check_reset_state(0);
        repeat (3) @(negedge clk);
        run_sweep(0, 0, 1'b0, 1, 15, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
